// File: rtl/glb_banked.sv
// Multi-bank global buffer: per-bank read ports with a 2-cycle pipeline and a
// shared 2-stage write port supporting overwrite and read-modify-write accumulate.
module glb_banked #(
    parameter int DATA_BITWIDTH = 32,
    parameter int BANK_NUM      = 3,
    parameter int BANK_DEPTH    = 8192,
    localparam int ADDR_W       = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1,
    localparam int BSEL_W       = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [BANK_NUM-1:0]               i_rd_req,
    input  logic [BANK_NUM*ADDR_W-1:0]        i_rd_addr,
    output logic [BANK_NUM-1:0]               o_rd_ready,
    output logic [BANK_NUM-1:0]               o_rd_valid,
    output logic [BANK_NUM*DATA_BITWIDTH-1:0] o_rd_data,
    input  logic                              i_wr_req,
    input  logic [BSEL_W-1:0]                 i_wr_bank,
    input  logic [ADDR_W-1:0]                 i_wr_addr,
    input  logic [DATA_BITWIDTH-1:0]          i_wr_data,
    input  logic                              i_wr_acc,
    output logic                              o_wr_err,
    output logic                              o_busy
);
    localparam int DW = DATA_BITWIDTH;

    logic              wr_bank_ok;
    logic              wr_accept;
    logic              fwd_hit;

    logic              s1_valid_reg;
    logic [BSEL_W-1:0] s1_bank_reg;
    logic [ADDR_W-1:0] s1_addr_reg;
    logic [DW-1:0]     s1_data_reg;
    logic              s1_acc_reg;
    logic              s1_fwd_reg;
    logic [DW-1:0]     s1_fwd_data_reg;
    logic              wr_err_reg;

    logic [DW-1:0]     s1_ram_q;
    logic [DW-1:0]     s1_operand;
    logic [DW-1:0]     s1_wdata;
    logic [DW-1:0]     ram_q [BANK_NUM];

    assign wr_bank_ok = 32'(i_wr_bank) < 32'(BANK_NUM);
    assign wr_accept  = i_wr_req && wr_bank_ok;
    // The op now in S1 commits after the RAM read of the incoming op, so its
    // result must be handed forward instead of the stale RAM word.
    assign fwd_hit    = s1_valid_reg && (s1_bank_reg == i_wr_bank) && (s1_addr_reg == i_wr_addr);

    always_comb begin
        s1_ram_q = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (s1_bank_reg == BSEL_W'(b)) begin
                s1_ram_q = ram_q[b];
            end
        end
        s1_operand = s1_fwd_reg ? s1_fwd_data_reg : s1_ram_q;
        s1_wdata   = s1_acc_reg ? (s1_operand + s1_data_reg) : s1_data_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg    <= 1'b0;
            s1_bank_reg     <= '0;
            s1_addr_reg     <= '0;
            s1_data_reg     <= '0;
            s1_acc_reg      <= 1'b0;
            s1_fwd_reg      <= 1'b0;
            s1_fwd_data_reg <= '0;
            wr_err_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= wr_accept;
            wr_err_reg   <= i_wr_req && !wr_bank_ok;
            if (wr_accept) begin
                s1_bank_reg     <= i_wr_bank;
                s1_addr_reg     <= i_wr_addr;
                s1_data_reg     <= i_wr_data;
                s1_acc_reg      <= i_wr_acc;
                s1_fwd_reg      <= fwd_hit;
                s1_fwd_data_reg <= s1_wdata;
            end
        end
    end

    assign o_busy   = s1_valid_reg;
    assign o_wr_err = wr_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
            logic [DW-1:0]     mem [BANK_DEPTH];
            logic              acc_steal;
            logic              rd_fire;
            logic              ram_re;
            logic              ram_we;
            logic [ADDR_W-1:0] ram_raddr;
            logic [DW-1:0]     ram_q_reg;
            logic              fire_reg;
            logic              valid_reg;
            logic [DW-1:0]     data_reg;

            // An accumulate borrows this bank's only read port for its operand fetch.
            assign acc_steal      = i_wr_req && i_wr_acc && (i_wr_bank == BSEL_W'(gi));
            assign o_rd_ready[gi] = !acc_steal;
            assign rd_fire        = i_rd_req[gi] && !acc_steal;
            assign ram_re         = rd_fire || acc_steal;
            assign ram_raddr      = acc_steal ? i_wr_addr : i_rd_addr[gi*ADDR_W +: ADDR_W];
            assign ram_we         = s1_valid_reg && (s1_bank_reg == BSEL_W'(gi));

            // Read-first RAM: a read colliding with the S1 commit sees the old word.
            always_ff @(posedge i_clk) begin
                if (ram_we) begin
                    mem[s1_addr_reg] <= s1_wdata;
                end
                if (ram_re) begin
                    ram_q_reg <= mem[ram_raddr];
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    fire_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    fire_reg  <= rd_fire;
                    valid_reg <= fire_reg;
                    if (fire_reg) begin
                        data_reg <= ram_q_reg;
                    end
                end
            end

            assign ram_q[gi]                = ram_q_reg;
            assign o_rd_valid[gi]           = valid_reg;
            assign o_rd_data[gi*DW +: DW]   = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_glb_banked.sv
// Bench for glb_banked: directed scenarios plus random traffic, checked every
// cycle against a sequential memory model with delayed write visibility.
module tb_glb_banked;
    localparam int DW = 32;
    localparam int BN = 3;
    localparam int AW = 13;
    localparam int BW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [BN-1:0]    rd_req = '0;
    logic [BN*AW-1:0] rd_addr = '0;
    logic [BN-1:0]    rd_ready;
    logic [BN-1:0]    rd_valid;
    logic [BN*DW-1:0] rd_data;
    logic             wr_req = 1'b0;
    logic [BW-1:0]    wr_bank = '0;
    logic [AW-1:0]    wr_addr = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             wr_acc = 1'b0;
    logic             wr_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    glb_banked dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_req   (rd_req),
        .i_rd_addr  (rd_addr),
        .o_rd_ready (rd_ready),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .i_wr_req   (wr_req),
        .i_wr_bank  (wr_bank),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_wr_acc   (wr_acc),
        .o_wr_err   (wr_err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: lmem is the program-order value (what forwarding guarantees),
    // vmem is what a read fired in the current cycle observes.
    typedef struct {int v; int key; bit [DW-1:0] val;} wr_t;
    typedef struct {int due; int b; bit [DW-1:0] val;} rd_t;
    bit [DW-1:0]   lmem [int];
    bit [DW-1:0]   vmem [int];
    wr_t           pend [$];
    rd_t           rdq  [$];
    int            cyc = 0;
    logic [BN-1:0] exp_valid = '0;
    logic [BN*DW-1:0] exp_data = '0;
    bit            prev_busy = 1'b0;
    bit            prev_err = 1'b0;
    int            valid_cnt [BN];

    always @(negedge clk) begin
        wr_t           w;
        rd_t           r;
        logic [BN-1:0] exp_ready;
        int            key;
        bit [DW-1:0]   nv;
        while (pend.size() > 0 && pend[0].v <= cyc) begin
            w = pend.pop_front();
            vmem[w.key] = w.val;
        end
        if (!rst_n) begin
            pend.delete();
            rdq.delete();
            lmem.delete();
            foreach (vmem[k]) lmem[k] = vmem[k];
            exp_data  = '0;
            prev_busy = 1'b0;
            prev_err  = 1'b0;
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_data", rd_data, 0);
            check("rst_wr_err", wr_err, 0);
            check("rst_busy", busy, 0);
        end else begin
            exp_valid = '0;
            while (rdq.size() > 0 && rdq[0].due <= cyc) begin
                r = rdq.pop_front();
                exp_valid[r.b] = 1'b1;
                exp_data[r.b*DW +: DW] = r.val;
            end
            for (int b = 0; b < BN; b++) exp_ready[b] = !(wr_req && wr_acc && int'(wr_bank) == b);
            check("rd_ready", rd_ready, exp_ready);
            check("rd_valid", rd_valid, exp_valid);
            check("rd_data", rd_data, exp_data);
            check("wr_err", wr_err, prev_err);
            check("busy", busy, prev_busy);
            for (int b = 0; b < BN; b++) begin
                if (rd_valid[b]) begin
                    valid_cnt[b]++;
                    $display("[%0d] rd bank=%0d data=%08h", cyc, b, rd_data[b*DW +: DW]);
                end
            end
            for (int b = 0; b < BN; b++) begin
                if (rd_req[b] && exp_ready[b]) begin
                    key   = b * 8192 + int'(rd_addr[b*AW +: AW]);
                    r.due = cyc + 2;
                    r.b   = b;
                    r.val = vmem.exists(key) ? vmem[key] : '0;
                    rdq.push_back(r);
                end
            end
            prev_busy = 1'b0;
            prev_err  = 1'b0;
            if (wr_req) begin
                if (int'(wr_bank) >= BN) begin
                    prev_err = 1'b1;
                    $display("[%0d] wr bank=%0d dropped", cyc, wr_bank);
                end else begin
                    key = int'(wr_bank) * 8192 + int'(wr_addr);
                    nv  = wr_acc ? ((lmem.exists(key) ? lmem[key] : '0) + wr_data) : wr_data;
                    lmem[key] = nv;
                    w.v = cyc + 2;
                    w.key = key;
                    w.val = nv;
                    pend.push_back(w);
                    prev_busy = 1'b1;
                    $display("[%0d] wr bank=%0d addr=%0d acc=%0d data=%08h -> %08h",
                             cyc, wr_bank, wr_addr, wr_acc, wr_data, nv);
                end
            end
        end
        cyc++;
    end

    function automatic logic [DW-1:0] pat(input int b, input int a);
        return 32'h5A00_0000 | 32'(b << 8) | 32'(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        rd_req = '0;
        wr_req = 1'b0;
        wr_acc = 1'b0;
    endtask

    task automatic wr(input int b, input int a, input logic [DW-1:0] d, input bit acc);
        wr_req  = 1'b1;
        wr_bank = BW'(b);
        wr_addr = AW'(a);
        wr_data = d;
        wr_acc  = acc;
        step();
    endtask

    task automatic rd_set(input int b, input int a);
        rd_req[b] = 1'b1;
        rd_addr[b*AW +: AW] = AW'(a);
    endtask

    task automatic read_expect(input string name, input int b, input int a, input logic [DW-1:0] v);
        rd_set(b, a);
        step();
        step();
        check({name, "_valid"}, rd_valid[b], 1);
        check(name, rd_data[b*DW +: DW], v);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_valid", rd_valid, 0);
        check("reset_data", rd_data, 0);
        check("reset_busy", busy, 0);
        check("reset_err", wr_err, 0);

        for (int b = 0; b < BN; b++)
            for (int a = 0; a < 32; a++) wr(b, a, pat(b, a), 1'b0);
        step();

        // Plain write, read one cycle later (old) and two cycles later (new)
        wr(1, 5, 32'hA5, 1'b0);
        check("plain_busy", busy, 1);
        rd_set(1, 5); step();
        rd_set(1, 5); step();
        check("raw_old_valid", rd_valid[1], 1);
        check("raw_old_data", rd_data[DW +: DW], 32'h5A00_0105);
        step();
        check("raw_new_valid", rd_valid[1], 1);
        check("raw_new_data", rd_data[DW +: DW], 32'hA5);

        // Back-to-back accumulates, wrap, and RAM-operand accumulate
        wr(1, 7, 32'd10, 1'b0);
        for (int i = 0; i < 4; i++) wr(1, 7, 32'd1, 1'b1);
        step();
        read_expect("acc_burst", 1, 7, 32'd14);
        wr(1, 9, 32'hFFFF_FFFF, 1'b0);
        wr(1, 9, 32'd2, 1'b1);
        step();
        read_expect("acc_wrap", 1, 9, 32'd1);
        wr(0, 3, 32'd100, 1'b0);
        step(); step();
        wr(0, 3, 32'd23, 1'b1);
        step();
        read_expect("acc_ram", 0, 3, 32'd123);

        // Accumulate steals bank0's read port; bank2 unaffected
        wr_req = 1'b1; wr_bank = 2'd0; wr_addr = 13'd4; wr_data = 32'd5; wr_acc = 1'b1;
        rd_set(0, 6); rd_set(2, 6);
        #1;
        check("steal_ready0", rd_ready[0], 0);
        check("steal_ready2", rd_ready[2], 1);
        step(); step();
        check("steal_no_valid0", rd_valid[0], 0);
        check("steal_valid2", rd_valid[2], 1);
        check("steal_data2", rd_data[2*DW +: DW], 32'h5A00_0206);
        wr_req = 1'b1; wr_bank = 2'd0; wr_addr = 13'd20; wr_data = 32'd9; wr_acc = 1'b0;
        rd_set(0, 6);
        #1;
        check("plain_ready0", rd_ready[0], 1);
        step(); step();
        check("plain_rd_data0", rd_data[DW-1:0], 32'h5A00_0006);
        step();

        // All banks reading every cycle
        for (int b = 0; b < BN; b++) valid_cnt[b] = 0;
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < BN; b++) rd_set(b, i);
            step();
        end
        step(); step();
        for (int b = 0; b < BN; b++) check("par_count", valid_cnt[b], 16);

        // Out-of-range bank
        wr(3, 5, 32'hDEAD_BEEF, 1'b0);
        check("err_pulse", wr_err, 1);
        check("err_busy", busy, 0);
        step();
        check("err_clear", wr_err, 0);
        read_expect("err_bank1", 1, 5, 32'hA5);
        read_expect("err_bank0", 0, 5, 32'h5A00_0005);
        read_expect("err_bank2", 2, 5, 32'h5A00_0205);

        // Random traffic with frequent address collisions
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                wr_req  = 1'b1;
                wr_bank = BW'($urandom_range(0, BN));
                wr_addr = AW'($urandom_range(0, 7));
                wr_acc  = 1'($urandom_range(0, 1));
                wr_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            end
            for (int b = 0; b < BN; b++)
                if ($urandom_range(0, 1) == 1) rd_set(b, $urandom_range(0, 31));
            step();
        end
        repeat (3) step();

        // Reset while an accumulate sits in S1
        wr(2, 3, 32'h1234, 1'b0);
        step();
        wr_req = 1'b1; wr_bank = 2'd2; wr_addr = 13'd3; wr_data = 32'd5; wr_acc = 1'b1;
        rd_set(0, 1);
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", rd_valid, 0);
        check("midrst_err", wr_err, 0);
        step();
        check("midrst_valid2", rd_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        read_expect("midrst_unchanged", 2, 3, 32'h1234);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glb_banked.md
# glb_banked

Parametrised multi-bank global buffer for the accelerator's GLB level: BANK_NUM independent single-read/single-write banks (ifmap, psum, weight, and spares), each with its own read request port and a 2-cycle registered read pipeline. One shared write port serves all banks. It supports plain writes and read-modify-write accumulate writes, used for psum accumulation. A one-deep forwarding path keeps back-to-back accumulates to the same address correct.

## Interface
- DATA_BITWIDTH, 32, word width; accumulate arithmetic uses this width.
- BANK_NUM, 3, number of banks, 1..16.
- BANK_DEPTH, 8192, words per bank.
- ADDR_W, clogb2(BANK_DEPTH-1), address width (derived; not overridden).
- BSEL_W, clogb2(BANK_NUM-1) (minimum 1), bank-select width (derived).
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rd_req  in  BANK_NUM  per-bank read request.
- i_rd_addr  in  BANK_NUM*ADDR_W  per-bank read address; bank b occupies bits [b*ADDR_W +: ADDR_W].
- o_rd_ready  out  BANK_NUM  per-bank read accept; combinational.
- o_rd_valid  out  BANK_NUM  per-bank read data valid.
- o_rd_data  out  BANK_NUM*DATA_BITWIDTH  per-bank read data.
- i_wr_req  in  1  write request; always accepted.
- i_wr_bank  in  BSEL_W  target bank.
- i_wr_addr  in  ADDR_W  target address.
- i_wr_data  in  DATA_BITWIDTH  write data or addend.
- i_wr_acc  in  1  1 = accumulate (mem += data), 0 = overwrite.
- o_wr_err  out  1  one-cycle pulse: write to bank >= BANK_NUM was dropped.
- o_busy  out  1  write pipeline stage 1 holds an op.

## Operation
- Storage: one RAM array per bank. Each bank has 1 synchronous read port (read-first) and 1 write port. Contents are not reset.
- Read port arbitration, per bank b:
  - An accumulate accepted to bank b in cycle T uses bank b's read port in T.
  - o_rd_ready[b] = !(i_wr_req && i_wr_acc && i_wr_bank==b).
  - A read fires when i_rd_req[b] && o_rd_ready[b].
  - A read that is not accepted has no effect; the requester must hold or retry it.
- Read pipeline: fire at T -> RAM read at T -> output register -> o_rd_valid[b]=1 with o_rd_data at T+2. Fully pipelined, one read per bank per cycle.
- o_rd_data[b] holds its last value while o_rd_valid[b]=0.
- Write pipeline (shared by all banks, 2 stages):
  - S0 (accept cycle T): latch bank, addr, data, acc. If acc, issue a RAM read of addr on the target bank. Bank >= BANK_NUM: op dropped, o_wr_err=1 at T+1.
  - S1 (cycle T+1): compute wdata = acc ? (operand + data) : data, wrapping mod 2^DATA_BITWIDTH with no saturation. RAM write commits on the T+1 -> T+2 edge.
- Forwarding:
  - If op B is accepted at T while op A is in S1 with the same bank and addr, B's operand at S1 is A's wdata, not the RAM output.
  - This applies for any A type (plain or acc).
- Read-after-write visibility:
  - An external read fired in the same cycle as a write's S1 commit, to the same bank and address, returns the old value.
  - A read fired one or more cycles after commit returns the new value.
- Throughput: one write per cycle, sustained, any mix of plain and acc.

## Timing
- Reset (async assert, sync release):
  - o_rd_valid=0, o_rd_data=0, o_wr_err=0, o_busy=0.
  - S1 and read pipelines cleared.
  - An in-flight S1 write is dropped and does not commit.
- Latency:
  - Read: 2 cycles, request to valid.
  - Write: visible to reads fired at T+2 or later.
  - Accumulate back-to-back to the same address: correct every cycle via forwarding.
- o_rd_ready is combinational from the i_wr_* inputs; no registered path.
- o_busy = S1 valid. It stays high under continuous writes and falls 1 cycle after the last accept.
- Simultaneous events:
  - Acc write and external read on different banks: both proceed.
  - Acc write and external read on the same bank: the read is stalled that cycle.
  - Plain write never blocks reads.

## Test plan
- Reset and plain traffic: after reset all outputs are 0. Write 0xA5 to bank1 addr 5 at T, read bank1 addr 5 at T+2 -> o_rd_valid[1]=1 at T+4 with data 0xA5. A read fired at T+1 returns the prior contents.
- Accumulate burst: bank1 addr 7 = 10. Accumulate +1 on 4 consecutive cycles -> final value 14, proving forwarding. Wrap case: 0xFFFFFFFF + 2 -> 0x00000001.
- Port steal: accumulate to bank0 with i_rd_req[0]=1 in the same cycle -> o_rd_ready[0]=0, no valid 2 cycles later. Concurrent read of bank2 completes normally.
- Parallel reads: all banks request every cycle for 16 cycles with incrementing addresses -> 16 valids per bank, in order, 2-cycle latency, data matching the preloaded pattern.
- Error: BANK_NUM=3, write to bank 3 -> o_wr_err pulses 1 cycle and no bank changes.
- Mid-op reset: assert i_rst_n low while an acc is in S1 -> target word unchanged, o_busy=0 immediately, o_rd_valid=0.
